led_share_ctrl: RTL and testbench

Arbiter and pattern sequencer that shares the single board LED (`o_LED_1`) between `N_REQ` requesters (heartbeat, status, error, debug). It grants one requester at a time with fixed priority, latches that requester's blink pattern, and plays it one bit per prescaled tick. It sits between the application logic and the LED pin, and its outputs are suitable as GAO probe points. Everything runs on the `i_clk` domain.

---
 rtl/led_share_pkg.sv | 12 +
 rtl/led_tick_gen.sv | 28 ++
 rtl/led_share_ctrl.sv | 113 +++++++++++
 tb/tb_led_share_ctrl.sv | 129 ++++++++++++
 4 files changed

// File: rtl/led_share_pkg.sv
// led_share_pkg: shared state encoding, width helper and default prescale for the LED sharing block
package led_share_pkg;

    typedef enum logic {IDLE, PLAY} state_t;

    localparam int DEF_TICK_DIV = 27_000_000 / 8;

    function automatic int cw(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// led_tick_gen: prescaler emitting a one-cycle tick when the count reaches TICK_DIV-1
module led_tick_gen
    import led_share_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = cw(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && cnt == LAST;

    // count while enabled, restart at each bit boundary, hold at zero when cleared
    always_ff @(posedge clk) begin
        if (clr)
            cnt <= '0;
        else if (en)
            cnt <= tick ? '0 : cnt + CW'(1);
    end

endmodule

// File: rtl/led_share_ctrl.sv
// led_share_ctrl: fixed-priority LED arbiter and pattern player; LED_SHARE_PREEMPT_EN enables bit-boundary preemption
module led_share_ctrl
    import led_share_pkg::*;
#(
    parameter int N_REQ    = 3,
    parameter int PAT_W    = 8,
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [N_REQ-1:0]       i_req,
    input  logic [N_REQ*PAT_W-1:0] i_pat,
    output logic [N_REQ-1:0]       o_grant,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_abort,
    output logic                   o_LED_1
);

    localparam int BW = cw(PAT_W);

    state_t             state, state_n;
    logic [N_REQ-1:0]   win, grant_n;
    logic [PAT_W-1:0]   pat_q, pat_n, win_pat;
    logic [BW-1:0]      bit_idx, bit_n;
    logic               led_n, done_n, abort_n;
    logic               tick, held, last;

    led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (i_clk),
        .clr  (!i_rst_n || state == IDLE),
        .en   (state == PLAY),
        .tick (tick)
    );

    assign o_busy = state == PLAY;
    assign win    = i_req & (~i_req + N_REQ'(1));
    assign held   = |(i_req & o_grant);
    assign last   = bit_idx == BW'(PAT_W - 1);

    // pattern of the lowest-index active requester
    always_comb begin
        win_pat = '0;
        for (int n = N_REQ - 1; n >= 0; n--)
            if (i_req[n]) win_pat = i_pat[n*PAT_W +: PAT_W];
    end

    // next state and outputs; completion outranks preemption, which outranks a drop
    always_comb begin
        state_n = state;
        grant_n = o_grant;
        pat_n   = pat_q;
        bit_n   = bit_idx;
        led_n   = o_LED_1;
        done_n  = 1'b0;
        abort_n = 1'b0;
        if (state == IDLE) begin
            led_n = 1'b0;
            if (|i_req) begin
                state_n = PLAY;
                grant_n = win;
                pat_n   = win_pat;
                bit_n   = '0;
                led_n   = win_pat[0];
            end
        end else if (tick && last) begin
            state_n = IDLE;
            grant_n = '0;
            led_n   = 1'b0;
            done_n  = 1'b1;
        end
`ifdef LED_SHARE_PREEMPT_EN
        else if (tick && |(i_req & (o_grant - N_REQ'(1)))) begin
            grant_n = win;
            pat_n   = win_pat;
            bit_n   = '0;
            led_n   = win_pat[0];
            abort_n = 1'b1;
        end
`endif
        else if (!held) begin
            state_n = IDLE;
            grant_n = '0;
            led_n   = 1'b0;
            abort_n = 1'b1;
        end else if (tick) begin
            bit_n = bit_idx + BW'(1);
            led_n = pat_q[bit_n];
        end
    end

    // state and registered outputs with synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            o_grant <= '0;
            pat_q   <= '0;
            bit_idx <= '0;
            o_LED_1 <= 1'b0;
            o_done  <= 1'b0;
            o_abort <= 1'b0;
        end else begin
            state   <= state_n;
            o_grant <= grant_n;
            pat_q   <= pat_n;
            bit_idx <= bit_n;
            o_LED_1 <= led_n;
            o_done  <= done_n;
            o_abort <= abort_n;
        end
    end

endmodule

// File: tb/tb_led_share_ctrl.sv
// tb_led_share_ctrl: table-driven directed checks of led_share_ctrl with N_REQ=3, PAT_W=8, TICK_DIV=4
module tb_led_share_ctrl;

    localparam logic [7:0]  P0   = 8'b1100_1011;
    localparam logic [7:0]  P1   = 8'b1010_0110;
    localparam logic [7:0]  P2   = 8'b0011_0101;
    localparam logic [23:0] PAT  = {P2, P1, P0};
    localparam logic [23:0] PATX = ~PAT;

    typedef struct {
        logic        rst_n;
        logic [2:0]  req;
        logic [23:0] pat;
        logic [2:0]  grant;
        logic        led, busy, done, abort;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req = '0;
    logic [23:0] pat = PAT;
    logic [2:0]  o_grant;
    logic        o_busy, o_done, o_abort, o_LED_1;

    int   checks = 0;
    int   errors = 0;
    vec_t vq[$];

    led_share_ctrl #(.N_REQ(3), .PAT_W(8), .TICK_DIV(4)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_req   (req),
        .i_pat   (pat),
        .o_grant (o_grant),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_abort (o_abort),
        .o_LED_1 (o_LED_1)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [2:0] rq, input logic [23:0] p,
                       input logic [2:0] g, input logic l, input logic b,
                       input logic d, input logic a);
        vec_t v;
        v.rst_n = r; v.req = rq; v.pat = p;
        v.grant = g; v.led = l; v.busy = b; v.done = d; v.abort = a;
        vq.push_back(v);
    endtask

    // playing edges e0..e1, where edge 1 is the grant edge and bit (e-1)/4 is shown
    task automatic add_play(input logic [2:0] rq, input logic [23:0] p, input logic [2:0] g,
                            input logic [7:0] lp, input int e0, input int e1);
        for (int e = e0; e <= e1; e++)
            add(1'b1, rq, p, g, lp[(e-1)/4], 1'b1, 1'b0, 1'b0);
    endtask

    task automatic check(input string name, input logic [6:0] exp);
        logic [6:0] got;
        got = {o_grant, o_LED_1, o_busy, o_done, o_abort};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got grant/led/busy/done/abort=%b expected %b", name, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic [2:0] rq);
        rst_n = r;
        req   = rq;
        @(posedge clk);
        #1;
    endtask

    initial begin
        add(1'b0, 3'b000, PAT, 3'b000, 0, 0, 0, 0);
        add(1'b0, 3'b000, PAT, 3'b000, 0, 0, 0, 0);
        add(1'b1, 3'b000, PAT, 3'b000, 0, 0, 0, 0);
        add_play(3'b010, PAT,  3'b010, P1, 1, 1);
        add_play(3'b010, PATX, 3'b010, P1, 2, 32);
        add(1'b1, 3'b000, PAT, 3'b000, 0, 0, 1, 0);
        add(1'b1, 3'b000, PAT, 3'b000, 0, 0, 0, 0);
        add_play(3'b110, PAT, 3'b010, P1, 1, 32);
        add(1'b1, 3'b100, PAT, 3'b000, 0, 0, 1, 0);
        add_play(3'b100, PAT, 3'b100, P2, 1, 3);
        add(1'b1, 3'b000, PAT, 3'b000, 0, 0, 0, 1);
        add(1'b1, 3'b000, PAT, 3'b000, 0, 0, 0, 0);
        add_play(3'b001, PAT, 3'b001, P0, 1, 9);
        add(1'b1, 3'b000, PAT, 3'b000, 0, 0, 0, 1);
        add(1'b1, 3'b000, PAT, 3'b000, 0, 0, 0, 0);
        add_play(3'b100, PAT, 3'b100, P2, 1, 14);
        add(1'b0, 3'b100, PAT, 3'b000, 0, 0, 0, 0);
        add_play(3'b100, PAT, 3'b100, P2, 1, 5);
`ifdef LED_SHARE_PREEMPT_EN
        add_play(3'b101, PAT, 3'b100, P2, 6, 8);
        add(1'b1, 3'b101, PAT, 3'b001, P0[0], 1, 0, 1);
        add_play(3'b001, PAT, 3'b001, P0, 2, 3);
`else
        add_play(3'b101, PAT, 3'b100, P2, 6, 32);
        add(1'b1, 3'b101, PAT, 3'b000, 0, 0, 1, 0);
        add_play(3'b001, PAT, 3'b001, P0, 1, 3);
`endif
        add(1'b1, 3'b000, PAT, 3'b000, 0, 0, 0, 1);
        add(1'b1, 3'b000, PAT, 3'b000, 0, 0, 0, 0);

        for (int i = 0; i < vq.size(); i++) begin
            pat = vq[i].pat;
            step(vq[i].rst_n, vq[i].req);
            check($sformatf("vec%0d", i),
                  {vq[i].grant, vq[i].led, vq[i].busy, vq[i].done, vq[i].abort});
        end

        step(1'b1, 3'b010);
        check("pulse_grant", 7'b010_0_1_0_0);
        step(1'b1, 3'b000);
        check("pulse_abort", 7'b000_0_0_0_1);
        step(1'b1, 3'b000);
        check("pulse_idle", 7'b000_0_0_0_0);
        step(1'b1, 3'b111);
        check("all_req_grant", {3'b001, P0[0], 3'b100});
        step(1'b0, 3'b111);
        check("reset_after_grant", 7'b000_0_0_0_0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
